// File: rtl/decoder_pkg.sv
// Shared types for the decoder-based round-robin arbiter.
package decoder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arbState_t;

endpackage

// File: rtl/decoder_rr_arbiter_if.sv
// Client request / grant bundle between the arbiter and its clients.
interface decoder_rr_arbiter_if #(
    parameter int HOLD_MAX = 8
);
    localparam int CNT_W = $clog2(HOLD_MAX + 1);

    logic [1:0]       req;
    logic [1:0]       gnt;
    logic             gnt_valid;
    logic             sel;
    logic [CNT_W-1:0] hold_cnt;

    modport master (
        input  req,
        output gnt,
        output gnt_valid,
        output sel,
        output hold_cnt
    );

    modport slave (
        output req,
        input  gnt,
        input  gnt_valid,
        input  sel,
        input  hold_cnt
    );

endinterface

// File: rtl/decoder_1bit.sv
// One-bit to one-hot decoder: in=0 raises out1, in=1 raises out2.
module decoder_1bit (
    input  logic in,
    output logic out1,
    output logic out2
);

    assign out1 = ~in;
    assign out2 = in;

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Two-client round-robin arbiter with a bounded hold time; the owner index
// drives a decoder_1bit whose one-hot outputs become the grant lines.
module decoder_rr_arbiter
    import decoder_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    decoder_rr_arbiter_if.master bus
);

    localparam int CNT_W = $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    arbState_t        r_state;
    logic             r_sel;
    logic             r_last;
    logic [CNT_W-1:0] r_holdCnt;

    arbState_t        w_stateNext;
    logic             w_selNext;
    logic             w_lastNext;
    logic [CNT_W-1:0] w_cntNext;

    logic w_ownReq;
    logic w_othReq;
    logic w_winner;
    logic w_valid;
    logic w_dec0;
    logic w_dec1;

    assign w_ownReq = bus.req[r_sel];
    assign w_othReq = bus.req[~r_sel];
    // Under simultaneous requests the client that did not win last time goes first.
    assign w_winner = (bus.req == 2'b11) ? ~r_last : bus.req[1];
    assign w_valid  = (r_state == OWN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_sel     <= 1'b0;
            r_last    <= 1'b1;
            r_holdCnt <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_sel     <= w_selNext;
            r_last    <= w_lastNext;
            r_holdCnt <= w_cntNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_selNext   = r_sel;
        w_lastNext  = r_last;
        w_cntNext   = r_holdCnt;
        case (r_state)
            IDLE: begin
                if (|bus.req) begin
                    w_stateNext = OWN;
                    w_selNext   = w_winner;
                    w_lastNext  = w_winner;
                    w_cntNext   = CNT_ONE;
                end
            end
            OWN: begin
                // Handoff on release or on hold expiry goes straight to the other client, no idle cycle.
                if ((!w_ownReq && w_othReq) || (w_othReq && r_holdCnt == CNT_MAX)) begin
                    w_selNext  = ~r_sel;
                    w_lastNext = ~r_sel;
                    w_cntNext  = CNT_ONE;
                end else if (!w_ownReq) begin
                    w_stateNext = IDLE;
                    w_cntNext   = '0;
                end else if (r_holdCnt != CNT_MAX) begin
                    w_cntNext = r_holdCnt + CNT_ONE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    decoder_1bit u_decoder (
        .in   (r_sel),
        .out1 (w_dec0),
        .out2 (w_dec1)
    );

    assign bus.gnt       = {w_dec1 & w_valid, w_dec0 & w_valid};
    assign bus.gnt_valid = w_valid;
    assign bus.sel       = r_sel;
    assign bus.hold_cnt  = r_holdCnt;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Scoreboard bench for decoder_rr_arbiter: HOLD_MAX=4 and HOLD_MAX=1 instances
// driven by the same directed request sequence.
module tb_decoder_rr_arbiter;

    logic clk;
    logic rst_n;

    decoder_rr_arbiter_if #(.HOLD_MAX(4)) bus4 ();
    decoder_rr_arbiter_if #(.HOLD_MAX(1)) bus1 ();

    decoder_rr_arbiter #(.HOLD_MAX(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    decoder_rr_arbiter #(.HOLD_MAX(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    g4;
        int    s4;
        int    c4;
        int    v4;
        int    g1;
        int    s1;
        int    c1;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state, index 0 = HOLD_MAX 4, index 1 = HOLD_MAX 1
    bit mValid[2];
    bit mSel[2];
    bit mLast[2];
    int mCnt[2];

    function automatic int modelGnt(input int k);
        if (!mValid[k]) return 0;
        return mSel[k] ? 2 : 1;
    endfunction

    task automatic modelStep(input int k, input int hm, input bit rstn, input logic [1:0] r);
        bit own;
        bit oth;
        if (!rstn) begin
            mValid[k] = 1'b0;
            mSel[k]   = 1'b0;
            mLast[k]  = 1'b1;
            mCnt[k]   = 0;
        end else if (!mValid[k]) begin
            if (r != 2'b00) begin
                mValid[k] = 1'b1;
                mSel[k]   = (r == 2'b11) ? ~mLast[k] : r[1];
                mLast[k]  = mSel[k];
                mCnt[k]   = 1;
            end
        end else begin
            own = r[mSel[k]];
            oth = r[~mSel[k]];
            if (oth && (!own || mCnt[k] == hm)) begin
                mSel[k]  = ~mSel[k];
                mLast[k] = mSel[k];
                mCnt[k]  = 1;
            end else if (!own) begin
                mValid[k] = 1'b0;
                mCnt[k]   = 0;
            end else if (mCnt[k] < hm) begin
                mCnt[k] = mCnt[k] + 1;
            end
        end
    endtask

    task automatic applyStimulus(input string tag, input bit rstn, input logic [1:0] r);
        exp_t e;
        @(negedge clk);
        rst_n    = rstn;
        bus4.req = r;
        bus1.req = r;
        modelStep(0, 4, rstn, r);
        modelStep(1, 1, rstn, r);
        e.tag = tag;
        e.g4  = modelGnt(0);
        e.s4  = int'(mSel[0]);
        e.c4  = mCnt[0];
        e.v4  = int'(mValid[0]);
        e.g1  = modelGnt(1);
        e.s1  = int'(mSel[1]);
        e.c1  = mCnt[1];
        expQ.push_back(e);
    endtask

    task automatic runPhase(input string tag, input bit rstn, input logic [1:0] r, input int n);
        for (int i = 0; i < n; i++) applyStimulus(tag, rstn, r);
    endtask

    task automatic checkOutput(input string name, input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s (%s) at %0t: got %0d, expected %0d", name, tag, $time, act, exp);
        end
    endtask

    // Monitor: outputs are presented every cycle, sampled 1ns after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("gnt4",       e.tag, int'(bus4.gnt),       e.g4);
                checkOutput("sel4",       e.tag, int'(bus4.sel),       e.s4);
                checkOutput("hold_cnt4",  e.tag, int'(bus4.hold_cnt),  e.c4);
                checkOutput("gnt_valid4", e.tag, int'(bus4.gnt_valid), e.v4);
                checkOutput("gnt1",       e.tag, int'(bus1.gnt),       e.g1);
                checkOutput("hold_cnt1",  e.tag, int'(bus1.hold_cnt),  e.c1);
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        bus4.req = 2'b11;
        bus1.req = 2'b11;
        modelStep(0, 4, 1'b0, 2'b11);
        modelStep(1, 1, 1'b0, 2'b11);

        $display("[TB] reset and first grant");
        runPhase("reset",      1'b0, 2'b11, 2);
        runPhase("firstGrant", 1'b1, 2'b11, 1);
        runPhase("drop",       1'b1, 2'b00, 1);

        $display("[TB] single client");
        runPhase("single1",    1'b1, 2'b10, 10);
        runPhase("singleDrop", 1'b1, 2'b00, 2);

        $display("[TB] contention");
        runPhase("contention", 1'b1, 2'b11, 12);

        $display("[TB] handoff");
        runPhase("own0",       1'b1, 2'b01, 2);
        runPhase("handoff",    1'b1, 2'b10, 1);
        runPhase("idle",       1'b1, 2'b00, 2);

        $display("[TB] late preempt");
        runPhase("alone0",     1'b1, 2'b01, 6);
        runPhase("preempt",    1'b1, 2'b11, 2);

        $display("[TB] mid-op reset");
        runPhase("toOwn1",     1'b1, 2'b11, 3);
        runPhase("midReset",   1'b0, 2'b11, 1);
        runPhase("postReset",  1'b1, 2'b11, 4);
        runPhase("tail",       1'b1, 2'b00, 2);

        @(negedge clk);
        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
        if (expQ.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", expQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
